// File: rtl/ctrl_capture_uart.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_capture_uart
// Purpose  : Captures DEPTH bytes on request, then streams them out as
//            back-to-back 8N1 UART frames, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_capture_uart #(
    parameter int DEPTH    = 16,
    parameter int BAUD_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in,
    input  logic       start,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(BAUD_DIV);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(BAUD_DIV - 1);
    localparam logic [3:0]         c_STOP_BIT = 4'd9;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_CAPTURE = 2'd1;
    localparam logic [1:0] c_SEND    = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_bit;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_done;
    logic [7:0]         r_buf [DEPTH];
    logic [7:0]         w_byte;
    logic               w_bit_end;
    logic               w_frame_end;
    logic               w_last_byte;
    logic               w_tx_bit;

    assign w_byte      = r_buf[r_idx];
    assign w_bit_end   = (r_cnt == c_LAST_CNT);
    assign w_frame_end = w_bit_end && (r_bit == c_STOP_BIT);
    assign w_last_byte = (r_idx == c_LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:    if (start) w_state_next = c_CAPTURE;
            c_CAPTURE: if (w_last_byte) w_state_next = c_SEND;
            c_SEND:    if (w_frame_end && w_last_byte) w_state_next = c_IDLE;
            default:   w_state_next = c_IDLE;
        endcase
    end

    // Frame position 0 is the start bit, 1..8 carry data LSB first, 9 is stop.
    always_comb begin
        w_tx_bit = 1'b1;
        case (r_bit)
            4'd0:    w_tx_bit = 1'b0;
            4'd1:    w_tx_bit = w_byte[0];
            4'd2:    w_tx_bit = w_byte[1];
            4'd3:    w_tx_bit = w_byte[2];
            4'd4:    w_tx_bit = w_byte[3];
            4'd5:    w_tx_bit = w_byte[4];
            4'd6:    w_tx_bit = w_byte[5];
            4'd7:    w_tx_bit = w_byte[6];
            4'd8:    w_tx_bit = w_byte[7];
            default: w_tx_bit = 1'b1;
        endcase
    end

    always_comb begin
        tx   = 1'b1;
        busy = 1'b0;
        case (r_state)
            c_CAPTURE: busy = 1'b1;
            c_SEND: begin
                busy = 1'b1;
                tx   = w_tx_bit;
            end
            default: begin
                tx   = 1'b1;
                busy = 1'b0;
            end
        endcase
    end

    assign done = r_done;

    // The byte index doubles as the write pointer during capture and the
    // read pointer during send; it is cleared on the hand-over edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_bit  <= '0;
            r_idx  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == c_SEND) && (w_state_next == c_IDLE);
            case (r_state)
                c_CAPTURE: begin
                    r_cnt <= '0;
                    r_bit <= '0;
                    r_idx <= w_last_byte ? '0 : r_idx + 1'b1;
                end
                c_SEND: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit == c_STOP_BIT) begin
                            r_bit <= '0;
                            r_idx <= w_last_byte ? '0 : r_idx + 1'b1;
                        end else begin
                            r_bit <= r_bit + 4'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt <= '0;
                    r_bit <= '0;
                    r_idx <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == c_CAPTURE) begin
            r_buf[r_idx] <= in;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_capture_uart.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_capture_uart
// Purpose  : Self-checking bench for ctrl_capture_uart against a frame-level
//            model of the expected UART stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_capture_uart;

    localparam int DEPTH    = 4;
    localparam int BAUD_DIV = 4;
    localparam int FRAME    = 10 * BAUD_DIV;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] in    = 8'h00;
    logic       tx;
    logic       busy;
    logic       done;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] acq_bytes [DEPTH];

    ctrl_capture_uart #(
        .DEPTH   (DEPTH),
        .BAUD_DIV(BAUD_DIV)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .in   (in),
        .start(start),
        .tx   (tx),
        .busy (busy),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line level t cycles after the capture-to-send edge.
    function automatic logic ref_tx(input int t);
        int frame;
        int pos;
        frame = t / FRAME;
        pos   = (t % FRAME) / BAUD_DIV;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return acq_bytes[frame][pos-1];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_tx"},   {7'd0, tx},   8'd1);
        chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
        chk({tag, "_done"}, {7'd0, done}, 8'd0);
    endtask

    task automatic fill_random();
        for (int k = 0; k < DEPTH; k++) acq_bytes[k] = 8'($urandom);
    endtask

    task automatic run_acq(input bit toggle_start, input bit hold_start, input int abort_at);
        start = 1'b1;
        tick();
        if (!hold_start) start = 1'b0;
        chk("e0_busy", {7'd0, busy}, 8'd1);
        chk("e0_tx",   {7'd0, tx},   8'd1);
        chk("e0_done", {7'd0, done}, 8'd0);
        for (int k = 0; k < DEPTH; k++) begin
            in = acq_bytes[k];
            tick();
            if (k < DEPTH - 1) begin
                chk("cap_busy", {7'd0, busy}, 8'd1);
                chk("cap_tx",   {7'd0, tx},   8'd1);
            end
        end
        for (int t = 0; t < DEPTH * FRAME; t++) begin
            in = 8'($urandom);
            if (t == abort_at) begin
                #3 rst_n = 1'b0;
                #1 check_idle("rst_async");
                repeat (3) @(posedge clk);
                #1 rst_n = 1'b1;
                start = 1'b0;
                check_idle("rst_release");
                for (int c = 0; c < 20; c++) begin
                    tick();
                    check_idle("rst_wait");
                end
                return;
            end
            chk("tx",   {7'd0, tx},   8'(ref_tx(t)));
            chk("busy", {7'd0, busy}, 8'd1);
            chk("done", {7'd0, done}, 8'd0);
            if (toggle_start) start = 1'($urandom_range(0, 1));
            tick();
        end
        if (!hold_start) start = 1'b0;
        chk("end_done", {7'd0, done}, 8'd1);
        chk("end_busy", {7'd0, busy}, 8'd0);
        chk("end_tx",   {7'd0, tx},   8'd1);
        if (!hold_start) begin
            for (int c = 0; c < 12; c++) begin
                tick();
                check_idle("post_idle");
            end
        end
    endtask

    initial begin
        // Asynchronous reset asserted mid-period from an unknown state.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_idle("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check_idle("reset_rel");
        for (int c = 0; c < 3; c++) begin
            tick();
            check_idle("reset_idle");
        end

        acq_bytes[0] = 8'h01;
        acq_bytes[1] = 8'h02;
        acq_bytes[2] = 8'h03;
        acq_bytes[3] = 8'h04;
        run_acq(1'b0, 1'b0, -1);

        fill_random();
        acq_bytes[0] = 8'hA5;
        run_acq(1'b0, 1'b0, -1);

        fill_random();
        run_acq(1'b1, 1'b0, -1);

        // Reset inside the start bit of the second frame, then recover.
        fill_random();
        run_acq(1'b0, 1'b0, FRAME + 1);
        fill_random();
        run_acq(1'b0, 1'b0, -1);

        // start held high: next acquisition begins on the edge after done.
        fill_random();
        run_acq(1'b0, 1'b1, -1);
        fill_random();
        run_acq(1'b0, 1'b0, -1);

        for (int r = 0; r < 4; r++) begin
            fill_random();
            run_acq(1'($urandom_range(0, 1)), 1'b0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
